// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants, fetch FSM encoding and PC helper
// Purpose: default reset/exception addresses, legal instruction window,
//          fetch-stage state encoding, sequential PC increment.
// Ports:   none (package).
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
  localparam logic [31:0] IM_LO_DEF      = 32'h0000_3000;
  localparam logic [31:0] IM_HI_DEF      = 32'h0000_6ffc;

  // FETCH: waiting on instruction memory; HOLD: word captured during a stall
  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  // Wraps modulo 2^32, so 32'hffff_fffc rolls over to 0
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_addr_chk.sv
// rtl/fetch_addr_chk.sv - combinational fetch address error check
// Purpose: flags a misaligned PC or one outside [IM_LO, IM_HI].
// Ports:   pc   in  32  fetch address
//          adel out 1   address error on instruction load
module fetch_addr_chk
  import cpu_pkg::*;
#(
  parameter logic [31:0] IM_LO = IM_LO_DEF,
  parameter logic [31:0] IM_HI = IM_HI_DEF
) (
  input  logic [31:0] pc,
  output logic        adel
);

  assign adel = (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);

endmodule

// File: rtl/f_fetch_unit.sv
// rtl/f_fetch_unit.sv - instruction fetch stage with delay-slot and exception redirect
// Purpose: owns the PC, issues instruction memory requests, buffers a word
//          across stalls, tracks pending branch redirects / delay-slot marks.
// Config:  FETCH_ERET_EN - when defined, eret_D redirects fetch to EPC with
//          no delay slot; otherwise eret_D and EPC are ignored.
// Ports:   clk, reset (sync, active-high)
//          stall, Req, EPC               pipeline control / exception
//          br_taken_D, br_target_D,
//          jump_D, eret_D                decode-stage redirect info
//          i_addr, i_req, i_rdata,
//          i_ready                       instruction memory
//          instr_F, WPC_F, BD_F, AdEL_F,
//          fetch_busy                    fetch-stage outputs
module f_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter logic [31:0] IM_LO      = IM_LO_DEF,
  parameter logic [31:0] IM_HI      = IM_HI_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        Req,
  input  logic [31:0] EPC,
  input  logic        br_taken_D,
  input  logic [31:0] br_target_D,
  input  logic        jump_D,
  input  logic        eret_D,
  output logic [31:0] i_addr,
  output logic        i_req,
  input  logic [31:0] i_rdata,
  input  logic        i_ready,
  output logic [31:0] instr_F,
  output logic [31:0] WPC_F,
  output logic        BD_F,
  output logic        AdEL_F,
  output logic        fetch_busy
);

  fetch_state_e state, state_n;
  logic [31:0]  pc, pc_n;
  logic [31:0]  buf_q, buf_n;
  logic         redir_pend, redir_pend_n;
  logic [31:0]  redir_target, redir_target_n;
  logic         bd_pend, bd_pend_n;
  logic         adel;
  logic         avail;
  logic         eret_fire;

  fetch_addr_chk #(
    .IM_LO(IM_LO),
    .IM_HI(IM_HI)
  ) u_addr_chk (
    .pc  (pc),
    .adel(adel)
  );

`ifdef FETCH_ERET_EN
  assign eret_fire = eret_D && !stall;
`else
  logic [32:0] eret_unused;
  assign eret_unused = {eret_D, EPC};
  assign eret_fire   = 1'b0;
`endif

  assign i_addr     = pc;
  assign i_req      = (state == FETCH) && !adel;
  // An erroring address has nothing to wait for, so it is available at once
  assign avail      = (state == HOLD) || i_ready || adel;
  assign fetch_busy = !avail;
  assign WPC_F      = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      buf_q        <= 32'h0;
      redir_pend   <= 1'b0;
      redir_target <= 32'h0;
      bd_pend      <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      buf_q        <= buf_n;
      redir_pend   <= redir_pend_n;
      redir_target <= redir_target_n;
      bd_pend      <= bd_pend_n;
    end
  end

  always_comb begin
    state_n        = state;
    pc_n           = pc;
    buf_n          = buf_q;
    redir_pend_n   = redir_pend;
    redir_target_n = redir_target;
    bd_pend_n      = bd_pend;
    instr_F        = 32'h0;
    BD_F           = 1'b0;
    AdEL_F         = 1'b0;

    if (Req) begin
      // Exception flushes whatever F holds, including any pending redirect
      pc_n         = EXC_VECTOR;
      state_n      = FETCH;
      redir_pend_n = 1'b0;
      bd_pend_n    = 1'b0;
    end else if (eret_fire) begin
      pc_n         = EPC;
      state_n      = FETCH;
      redir_pend_n = 1'b0;
      bd_pend_n    = 1'b0;
    end else if (stall) begin
      // Capture a returning word so memory is not re-read after the stall
      if (i_req && i_ready) begin
        buf_n   = i_rdata;
        state_n = HOLD;
      end
    end else if (avail) begin
      if (state == HOLD)
        instr_F = buf_q;
      else if (!adel)
        instr_F = i_rdata;
      BD_F   = jump_D || bd_pend;
      AdEL_F = adel;
      if (redir_pend)
        pc_n = redir_target;
      else if (br_taken_D)
        pc_n = br_target_D;
      else
        pc_n = pc_plus4(pc);
      state_n      = FETCH;
      redir_pend_n = 1'b0;
      bd_pend_n    = 1'b0;
    end else begin
      // Delay slot has not arrived yet: remember the branch for when it does
      if (br_taken_D) begin
        redir_pend_n   = 1'b1;
        redir_target_n = br_target_D;
      end
      if (jump_D)
        bd_pend_n = 1'b1;
    end
  end

endmodule
